// File: rtl/inst_mem_loader_pkg.sv
// Constants shared by the instruction loader, the debug unit and the bench:
// halt instruction value, bytes per instruction and the loader FSM encoding.
package inst_mem_loader_pkg;

    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          WORD_BITS      = BYTES_PER_WORD * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs incoming bytes MSB first into one instruction word. The completed word
// is presented combinationally in the cycle its last byte arrives.
module word_assembler
    import inst_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_ready
);

    logic [WORD_BITS-1:0] shift_reg;
    logic [1:0]           byte_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (byte_valid) begin
            shift_reg <= {shift_reg[WORD_BITS-9:0], byte_in};
            byte_cnt  <= byte_cnt + 2'd1;
        end
    end

    // Including the live byte lets the writer register the word on the same
    // edge that samples the final byte, giving one cycle of latency.
    assign word_out   = {shift_reg[WORD_BITS-9:0], byte_in};
    assign word_ready = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a program image from a byte stream into instruction memory, one word per
// four bytes, stopping on the halt instruction or when the address space is full.
module inst_mem_loader #(
    parameter int                   RAM_WIDTH     = 32,
    parameter int                   RAM_ADDR_BITS = 20,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD     = inst_mem_loader_pkg::HALT_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     wr_en,
    output logic [RAM_ADDR_BITS-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [RAM_ADDR_BITS:0]   word_count
);
    import inst_mem_loader_pkg::*;

    load_state_t          state;
    logic [WORD_BITS-1:0] word_out;
    logic                 word_ready;
    logic                 idle_like;
    logic                 is_halt;
    logic                 addr_last;
    logic                 finishing;
    logic                 byte_accept;
    logic                 clear;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign is_halt   = (wr_data == HALT_WORD);
    assign addr_last = (wr_addr == {RAM_ADDR_BITS{1'b1}});
    assign finishing = is_halt || addr_last;
    assign clear     = start && idle_like;

    // A byte arriving during the write cycle starts the next word, unless this
    // write ends the load, in which case it is dropped.
    assign byte_accept = rx_valid &&
                         ((state == ST_RECV) || ((state == ST_WRITE) && !finishing));

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .byte_in    (rx_data),
        .byte_valid (byte_accept),
        .word_out   (word_out),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        wr_addr    <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (word_ready) begin
                        wr_en      <= 1'b1;
                        wr_data    <= word_out;
                        word_count <= word_count + (RAM_ADDR_BITS+1)'(1);
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (is_halt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (addr_last) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        wr_addr <= wr_addr + RAM_ADDR_BITS'(1);
                        state   <= ST_RECV;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench: one full-size loader and one with a 4-word address space,
// each write captured on the falling edge and compared to hand-computed words.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, rx_valid_a = 1'b0;
    logic [7:0]  rx_data_a = 8'h00;
    logic        wr_en_a, busy_a, done_a, overflow_a;
    logic [19:0] wr_addr_a;
    logic [31:0] wr_data_a;
    logic [20:0] word_count_a;

    logic        start_b = 1'b0, rx_valid_b = 1'b0;
    logic [7:0]  rx_data_b = 8'h00;
    logic        wr_en_b, busy_b, done_b, overflow_b;
    logic [1:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [2:0]  word_count_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] wr_q_a[$];
    logic [63:0] wr_q_b[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk(clk), .reset(reset), .start(start_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a),
        .overflow(overflow_a), .word_count(word_count_a)
    );

    inst_mem_loader #(.RAM_ADDR_BITS(2)) dut_small (
        .clk(clk), .reset(reset), .start(start_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b),
        .overflow(overflow_b), .word_count(word_count_b)
    );

    always @(negedge clk) begin
        if (wr_en_a) wr_q_a.push_back({12'h000, wr_addr_a, wr_data_a});
        if (wr_en_b) wr_q_b.push_back({30'h0, wr_addr_b, wr_data_b});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_byte(input int sel, input logic [7:0] b);
        if (sel == 0) begin rx_valid_a = 1'b1; rx_data_a = b; end
        else          begin rx_valid_b = 1'b1; rx_data_b = b; end
        @(negedge clk);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input int gap, input bit exp_wr);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(sel, tmp[31-8*k -: 8]);
            check_eq($sformatf("wr_en_lat sel%0d %08h b%0d", sel, w, k),
                     {63'd0, (sel == 0) ? wr_en_a : wr_en_b},
                     {63'd0, (k == 3) && exp_wr});
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic compare_writes(input string tag, input int sel);
        int n;
        n = (sel == 0) ? wr_q_a.size() : wr_q_b.size();
        check_eq({tag, "_nwrites"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < n)
                check_eq($sformatf("%s_w%0d", tag, i),
                         (sel == 0) ? wr_q_a[i] : wr_q_b[i], exp_q[i]);
        wr_q_a.delete();
        wr_q_b.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input bit d, input bit ovf, input int cnt);
        check_eq({tag, "_done"},     {63'd0, done_a},     {63'd0, d});
        check_eq({tag, "_busy"},     {63'd0, busy_a},     {63'd0, !d});
        check_eq({tag, "_overflow"}, {63'd0, overflow_a}, {63'd0, ovf});
        check_eq({tag, "_count"},    {43'd0, word_count_a}, 64'(cnt));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check_eq("rst_wr_en",  {63'd0, wr_en_a},      64'd0);
        check_eq("rst_addr",   {44'd0, wr_addr_a},    64'd0);
        check_eq("rst_data",   {32'd0, wr_data_a},    64'd0);
        check_eq("rst_busy",   {63'd0, busy_a},       64'd0);
        check_eq("rst_done",   {63'd0, done_a},       64'd0);
        check_eq("rst_ovf",    {63'd0, overflow_a},   64'd0);
        check_eq("rst_count",  {43'd0, word_count_a}, 64'd0);

        // Back-to-back load ending on the halt word
        pulse_start(0);
        check_eq("t1_busy_after_start", {63'd0, busy_a}, 64'd1);
        send_word(0, 32'h0102_0304, 0, 1'b1);
        send_word(0, 32'h1122_3344, 0, 1'b1);
        send_word(0, 32'hFFFF_FFFF, 0, 1'b1);
        @(negedge clk);
        check_status("t1", 1'b1, 1'b0, 3);
        exp_q = '{{32'd0, 32'h0102_0304}, {32'd1, 32'h1122_3344}, {32'd2, 32'hFFFF_FFFF}};
        compare_writes("t1", 0);

        // Same stream with five idle cycles between bytes
        pulse_start(0);
        check_eq("t2_done_cleared", {63'd0, done_a}, 64'd0);
        check_eq("t2_count_cleared", {43'd0, word_count_a}, 64'd0);
        send_word(0, 32'h0102_0304, 5, 1'b1);
        send_word(0, 32'h1122_3344, 5, 1'b1);
        send_word(0, 32'hFFFF_FFFF, 5, 1'b1);
        check_status("t2", 1'b1, 1'b0, 3);
        exp_q = '{{32'd0, 32'h0102_0304}, {32'd1, 32'h1122_3344}, {32'd2, 32'hFFFF_FFFF}};
        compare_writes("t2", 0);

        // 4-word address space: fifth word must never be written
        pulse_start(1);
        send_word(1, 32'h1000_0001, 0, 1'b1);
        send_word(1, 32'h1000_0002, 0, 1'b1);
        send_word(1, 32'h1000_0003, 0, 1'b1);
        send_word(1, 32'h1000_0004, 0, 1'b1);
        send_word(1, 32'h1000_0005, 0, 1'b0);
        @(negedge clk);
        check_eq("t3_done",     {63'd0, done_b},       64'd1);
        check_eq("t3_busy",     {63'd0, busy_b},       64'd0);
        check_eq("t3_overflow", {63'd0, overflow_b},   64'd1);
        check_eq("t3_count",    {61'd0, word_count_b}, 64'd4);
        exp_q = '{{32'd0, 32'h1000_0001}, {32'd1, 32'h1000_0002},
                  {32'd2, 32'h1000_0003}, {32'd3, 32'h1000_0004}};
        compare_writes("t3", 1);

        // Reset after two bytes, then bytes in IDLE, then a clean word
        pulse_start(0);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t4_busy_after_reset", {63'd0, busy_a}, 64'd0);
        check_eq("t4_count_after_reset", {43'd0, word_count_a}, 64'd0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h55);
        @(negedge clk);
        pulse_start(0);
        send_word(0, 32'hAABB_CCDD, 0, 1'b1);
        @(negedge clk);
        check_eq("t4_count", {43'd0, word_count_a}, 64'd1);
        exp_q = '{{32'd0, 32'hAABB_CCDD}};
        compare_writes("t4", 0);

        // start mid-word is ignored; bytes in DONE are ignored
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        pulse_start(0);
        send_byte(0, 8'h56);
        send_byte(0, 8'h78);
        check_eq("t5_wr_en", {63'd0, wr_en_a}, 64'd1);
        send_word(0, 32'hFFFF_FFFF, 0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(0, 8'h99);
        check_status("t5", 1'b1, 1'b0, 3);
        check_eq("t5_addr_hold", {44'd0, wr_addr_a}, 64'd2);
        exp_q = '{{32'd1, 32'h1234_5678}, {32'd2, 32'hFFFF_FFFF}};
        compare_writes("t5", 0);

        // Reload after done
        pulse_start(0);
        send_word(0, 32'hDEAD_BEEF, 0, 1'b1);
        send_word(0, 32'hFFFF_FFFF, 0, 1'b1);
        @(negedge clk);
        check_status("t6", 1'b1, 1'b0, 2);
        exp_q = '{{32'd0, 32'hDEAD_BEEF}, {32'd1, 32'hFFFF_FFFF}};
        compare_writes("t6", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
